tone_scheduler: RTL and testbench
=================================

TONE_SCHEDULER -- requirements
Module: tone_scheduler

Interface
REQ-001 SHALL have parameter N, default 16, the divide-number width driven to the variable divider.
REQ-002 SHALL have parameter DUR_W, default 12, the note-duration width in tick units.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port tick, input, 1, a one-cycle duration time-base strobe (e.g. 1 ms).
REQ-006 SHALL have port stop, input, 1, a synchronous abort of the current note.
REQ-007 SHALL have ports req0/req1, input, 1 each, requester note requests.
REQ-008 SHALL have ports div0/div1, input, N each, requested divide numbers.
REQ-009 SHALL have ports dur0/dur1, input, DUR_W each, requested durations in ticks.
REQ-010 SHALL have port ack, output, 2, a one-hot one-cycle grant pulse per requester.
REQ-011 SHALL have port div_num, output, N, the registered divide number for the divider.
REQ-012 SHALL have port div_rst, output, 1, the active-high divider restart pulse.
REQ-013 SHALL have port gate, output, 1, high while the tone is audible.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, PLAY and GAP.
REQ-016 In IDLE, with any req high at an edge, SHALL go to LOAD; winner's div/dur captured at the same edge, its ack bit high for exactly the following cycle.
REQ-017 Arbitration SHALL be round-robin: on a tie, grant the requester not granted last; the last-granted pointer resets to 1, so req0 wins the first tie.
REQ-018 A requester SHALL hold req and data stable until its ack; req held high after ack is a new request.
REQ-019 Captured div values 0 or 1 SHALL be clamped to 2 so the divider never underflows.
REQ-020 LOAD SHALL last one cycle, with div_rst=1 and div_num already holding the new value; gate=0.
REQ-021 LOAD SHALL go to PLAY; a captured duration of 0 SHALL instead go to IDLE with no PLAY/GAP and gate never high.
REQ-022 PLAY SHALL hold gate=1 and load the counter with dur, decrementing by 1 on each tick.
REQ-023 When a tick arrives with the counter at 1, PLAY SHALL go to GAP; ticks outside PLAY/GAP SHALL be ignored.
REQ-024 GAP SHALL hold gate=0 until the next tick, then go to IDLE.
REQ-025 Requests during LOAD/PLAY/GAP SHALL be held off, with no ack, until IDLE.
REQ-026 stop=1 in any state SHALL force IDLE at the next edge with gate=0; a pending ack SHALL be issued only if the capture edge occurred before stop.
REQ-027 stop and req both high in IDLE SHALL result in IDLE with no grant, stop taking priority.
REQ-028 div_num SHALL hold its last value in IDLE, GAP and after stop.
REQ-029 Counters SHALL not wrap: dur of all ones plays 2^DUR_W-1 ticks exactly.
REQ-030 Minimum turnaround SHALL be 1 IDLE cycle between GAP exit and the next LOAD.

Reset
REQ-031 rst low SHALL asynchronously force IDLE with ack=00, div_num=2, div_rst=1, gate=0, busy=0, counter=0 and the round-robin pointer at requester 1.
REQ-032 Reset assertion mid-note SHALL silence gate immediately, without waiting for clk.
REQ-033 Reset release SHALL be taken synchronously, with div_rst=0 from the first clk edge after release.

Verification
REQ-034 Single note: req0, div0=100, dur0=3 -> ack=01 one cycle; div_rst pulses; div_num=100; gate high for exactly 3 ticks; one tick of GAP; busy falls.
REQ-035 Tie: req0 and req1 together from reset -> req0 granted first, req1 granted in the IDLE after that note; repeating the tie -> req0 granted again.
REQ-036 Clamp and zero: div1=1, dur1=5 -> div_num=2; div0=50, dur0=0 -> ack issued, gate stays 0, returns to IDLE.
REQ-037 Abort: stop pulsed at the 2nd tick of a 10-tick note -> gate=0 and busy=0 next cycle; div_num keeps its value.
REQ-038 Reset mid-PLAY: rst low between clk edges -> gate=0 at once; after release all outputs equal their REQ-031 values and the next tie grants req0.

Source files
------------

// File: rtl/tone_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tone_scheduler
//  Brief    : Two-requester round-robin note scheduler driving a variable
//             tone divider (divide number, restart pulse, audible gate).
//  Revision : 1.0 - initial release
// ============================================================================
module tone_scheduler #(
    parameter int N     = 16,
    parameter int DUR_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             stop,
    input  logic             req0,
    input  logic             req1,
    input  logic [N-1:0]     div0,
    input  logic [N-1:0]     div1,
    input  logic [DUR_W-1:0] dur0,
    input  logic [DUR_W-1:0] dur1,
    output logic [1:0]       ack,
    output logic [N-1:0]     div_num,
    output logic             div_rst,
    output logic             gate,
    output logic             busy
);

    localparam logic [1:0]       c_ST_IDLE = 2'd0;
    localparam logic [1:0]       c_ST_LOAD = 2'd1;
    localparam logic [1:0]       c_ST_PLAY = 2'd2;
    localparam logic [1:0]       c_ST_GAP  = 2'd3;
    // Smallest divide number the divider can count down without underflow.
    localparam logic [N-1:0]     c_DIV_MIN = N'(2);
    localparam logic [DUR_W-1:0] c_DUR_ONE = DUR_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [DUR_W-1:0] r_cnt;
    logic [DUR_W-1:0] w_cnt_nxt;
    logic             r_last;      // 1: requester 1 was granted most recently
    logic [1:0]       r_ack;
    logic [N-1:0]     r_div_num;
    logic             r_div_rst;
    logic             r_gate;
    logic [1:0]       w_grant;
    logic             w_capture;
    logic [N-1:0]     w_sel_div;
    logic [DUR_W-1:0] w_sel_dur;
    logic [N-1:0]     w_clamp_div;

    // Round-robin arbitration: a tie goes to the requester not served last.
    always_comb begin
        w_grant = 2'b00;
        if (req0 && req1) begin
            w_grant = r_last ? 2'b01 : 2'b10;
        end else if (req0) begin
            w_grant = 2'b01;
        end else if (req1) begin
            w_grant = 2'b10;
        end
    end

    assign w_sel_div   = w_grant[1] ? div1 : div0;
    assign w_sel_dur   = w_grant[1] ? dur1 : dur0;
    assign w_clamp_div = (w_sel_div < c_DIV_MIN) ? c_DIV_MIN : w_sel_div;

    // Next-state and counter logic; stop overrides everything, including a grant.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        if (stop) begin
            w_state_nxt = c_ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (|w_grant) begin
                        w_state_nxt = c_ST_LOAD;
                        w_capture   = 1'b1;
                        w_cnt_nxt   = w_sel_dur;
                    end
                end
                c_ST_LOAD: begin
                    // A zero-length note is acknowledged but never sounds.
                    w_state_nxt = (r_cnt == '0) ? c_ST_IDLE : c_ST_PLAY;
                end
                c_ST_PLAY: begin
                    if (tick) begin
                        if (r_cnt == c_DUR_ONE) begin
                            w_state_nxt = c_ST_GAP;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt - c_DUR_ONE;
                        end
                    end
                end
                c_ST_GAP: begin
                    if (tick) begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, capture and registered outputs; reset silences the tone at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_last    <= 1'b1;
            r_ack     <= 2'b00;
            r_div_num <= c_DIV_MIN;
            r_div_rst <= 1'b1;
            r_gate    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ack     <= w_capture ? w_grant : 2'b00;
            r_div_rst <= (w_state_nxt == c_ST_LOAD);
            r_gate    <= (w_state_nxt == c_ST_PLAY);
            if (w_capture) begin
                r_last    <= w_grant[1];
                r_div_num <= w_clamp_div;
            end
        end
    end

    assign ack     = r_ack;
    assign div_num = r_div_num;
    assign div_rst = r_div_rst;
    assign gate    = r_gate;
    assign busy    = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tone_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tone_scheduler
//  Brief    : Self-checking bench for tone_scheduler; note-level reference
//             model (grant rule, clamp rule, tick counting) with random notes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tone_scheduler;

    localparam int N     = 16;
    localparam int DUR_W = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick;
    logic             stop;
    logic             req0;
    logic             req1;
    logic [N-1:0]     div0;
    logic [N-1:0]     div1;
    logic [DUR_W-1:0] dur0;
    logic [DUR_W-1:0] dur1;
    logic [1:0]       ack;
    logic [N-1:0]     div_num;
    logic             div_rst;
    logic             gate;
    logic             busy;

    int       vectors      = 0;
    int       miscompares  = 0;
    int       last_granted = 1;
    logic [1:0] pend       = 2'b00;

    always #5 clk = ~clk;

    tone_scheduler #(.N(N), .DUR_W(DUR_W)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .stop    (stop),
        .req0    (req0),
        .req1    (req1),
        .div0    (div0),
        .div1    (div1),
        .dur0    (dur0),
        .dur1    (dur1),
        .ack     (ack),
        .div_num (div_num),
        .div_rst (div_rst),
        .gate    (gate),
        .busy    (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] rand_div();
        case ($urandom_range(3, 0))
            0:       rand_div = '0;
            1:       rand_div = N'(1);
            default: rand_div = N'($urandom);
        endcase
    endfunction

    // One complete note from an IDLE negedge back to the next IDLE negedge.
    task automatic play_note(input logic [1:0] mask, input int spacing_max);
        int         who;
        int         d;
        int         ticks;
        logic [N-1:0] exp_div;
        req0 = mask[0];
        req1 = mask[1];
        if (mask == 2'b11) who = 1 - last_granted;
        else               who = mask[1] ? 1 : 0;
        d       = who ? int'(dur1) : int'(dur0);
        exp_div = who ? div1 : div0;
        if (exp_div < N'(2)) exp_div = N'(2);
        @(negedge clk);
        check("load_ack", ack, who ? 2 : 1);
        check("load_div_num", div_num, exp_div);
        check("load_div_rst", div_rst, 1);
        check("load_gate", gate, 0);
        check("load_busy", busy, 1);
        last_granted = who;
        if (who == 1) req1 = 1'b0;
        else          req0 = 1'b0;
        pend = {req1, req0};
        @(negedge clk);
        check("ack_one_cycle", ack, 0);
        check("div_rst_one_cycle", div_rst, 0);
        if (d == 0) begin
            check("zero_dur_busy", busy, 0);
            check("zero_dur_gate", gate, 0);
        end else begin
            ticks = 0;
            while (gate === 1'b1 && ticks < d + 2) begin
                repeat ($urandom_range(spacing_max, 0)) begin
                    @(negedge clk);
                    check("held_off_play", ack, 0);
                end
                tick = 1'b1;
                @(negedge clk);
                tick = 1'b0;
                ticks++;
            end
            check("gate_tick_count", ticks, d);
            check("gap_gate", gate, 0);
            check("gap_busy", busy, 1);
            check("gap_div_num", div_num, exp_div);
            repeat ($urandom_range(2, 0)) begin
                @(negedge clk);
                check("gap_wait_busy", busy, 1);
                check("held_off_gap", ack, 0);
            end
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            check("idle_busy", busy, 0);
            check("idle_ack", ack, 0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b0;
        tick = 1'b0;
        stop = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        div0 = '0;
        div1 = '0;
        dur0 = '0;
        dur1 = '0;
        repeat (2) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_div_num", div_num, 2);
        check("rst_div_rst", div_rst, 1);
        check("rst_gate", gate, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        @(negedge clk);
        check("release_div_rst", div_rst, 0);
        check("release_busy", busy, 0);

        // Tie from reset: req0 first, then req1, then req0 wins a repeated tie.
        div0 = N'(100); dur0 = DUR_W'(3);
        div1 = N'(200); dur1 = DUR_W'(2);
        play_note(2'b11, 1);
        check("tie_first_req0", last_granted, 0);
        play_note(pend, 1);
        check("tie_second_req1", last_granted, 1);
        play_note(2'b11, 2);
        check("tie_repeat_req0", last_granted, 0);
        while (pend != 2'b00) play_note(pend, 1);

        // Single note on requester 0.
        div0 = N'(100); dur0 = DUR_W'(3);
        play_note(2'b01, 2);

        // Clamp of a divide number of 1, then a zero-duration note.
        div1 = N'(1); dur1 = DUR_W'(5);
        play_note(2'b10, 1);
        div0 = N'(50); dur0 = DUR_W'(0);
        play_note(2'b01, 1);

        // Randomised notes with overlapping requests.
        for (int i = 0; i < 24; i++) begin
            logic [1:0] m;
            m = pend | 2'($urandom_range(3, 1));
            if (!pend[0] && m[0]) begin
                div0 = rand_div();
                dur0 = DUR_W'($urandom_range(5, 0));
            end
            if (!pend[1] && m[1]) begin
                div1 = rand_div();
                dur1 = DUR_W'($urandom_range(5, 0));
            end
            play_note(m, 3);
        end
        while (pend != 2'b00) play_note(pend, 1);

        // Longest note: all-ones duration with a tick every cycle.
        div0 = N'(7); dur0 = '1;
        play_note(2'b01, 0);

        // stop with a request in IDLE: no grant.
        req0 = 1'b1; stop = 1'b1;
        @(negedge clk);
        check("stop_idle_ack", ack, 0);
        check("stop_idle_busy", busy, 0);
        req0 = 1'b0; stop = 1'b0;

        // stop during LOAD: the ack from the earlier capture still appears.
        div1 = N'(9); dur1 = DUR_W'(4); req1 = 1'b1;
        @(negedge clk);
        check("stop_load_ack", ack, 2);
        last_granted = 1;
        req1 = 1'b0; stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_load_busy", busy, 0);
        check("stop_load_gate", gate, 0);
        check("stop_load_div_num", div_num, 9);

        // Abort at the 2nd tick of a 10-tick note.
        div0 = N'(300); dur0 = DUR_W'(10); req0 = 1'b1;
        @(negedge clk);
        check("abort_ack", ack, 1);
        last_granted = 0;
        req0 = 1'b0;
        @(negedge clk);
        check("abort_play_gate", gate, 1);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b1; stop = 1'b1;
        @(negedge clk);
        tick = 1'b0; stop = 1'b0;
        check("abort_gate", gate, 0);
        check("abort_busy", busy, 0);
        check("abort_div_num", div_num, 300);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("idle_tick_ignored", busy, 0);

        // Asynchronous reset in the middle of a note.
        div1 = N'(77); dur1 = DUR_W'(8); req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        @(negedge clk);
        check("mid_play_gate", gate, 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_gate", gate, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_ack", ack, 0);
        check("async_rst_div_rst", div_rst, 1);
        check("async_rst_div_num", div_num, 2);
        @(negedge clk);
        rst = 1'b1;
        last_granted = 1;
        pend = 2'b00;
        @(negedge clk);
        check("post_rst_div_rst", div_rst, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_gate", gate, 0);
        check("post_rst_div_num", div_num, 2);
        div0 = N'(11); dur0 = DUR_W'(1);
        div1 = N'(12); dur1 = DUR_W'(1);
        play_note(2'b11, 1);
        check("post_rst_tie_req0", last_granted, 0);
        while (pend != 2'b00) play_note(pend, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
